// File: rtl/framed_shiftregister.sv
// Framed serialiser/deserialiser driven by peripheral-clock edge strobes.
// Samples on the rising strobe, shifts on the falling strobe, and hands each completed frame to the consumer through a valid/ack handshake.
module framed_shiftregister #(
    parameter int unsigned width    = 8,
    parameter int unsigned lsbFirst = 0,
    parameter int unsigned cntWidth = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                peripheralClkEdgePos,
    input  logic                peripheralClkEdgeNeg,
    input  logic                parallelLoad,
    input  logic [width-1:0]    parallelDataIn,
    input  logic                serialDataIn,
    input  logic                rxAck,
    output logic                serialDataOut,
    output logic [width-1:0]    parallelDataOut,
    output logic [width-1:0]    rxData,
    output logic                rxValid,
    output logic                frameDone,
    output logic                overrun,
    output logic [cntWidth-1:0] bitCount
);

    localparam logic [cntWidth-1:0] lastCount = cntWidth'(width - 1);

    logic [width-1:0]    mem, memNext, shifted;
    logic                sampledBit, sampledNext;
    logic [cntWidth-1:0] countNext;
    logic [width-1:0]    rxDataNext;
    logic                rxValidNext, frameDoneNext, overrunNext;
    logic                doShift, frameEnd;

    // The shift always consumes the sampledBit captured before this edge.
    always_comb begin
        if (lsbFirst != 0) begin
            shifted = {sampledBit, mem[width-1:1]};
        end else begin
            shifted = {mem[width-2:0], sampledBit};
        end
    end

    assign doShift  = peripheralClkEdgeNeg && !parallelLoad;
    assign frameEnd = doShift && (bitCount == lastCount);

    always_comb begin
        memNext       = mem;
        sampledNext   = sampledBit;
        countNext     = bitCount;
        rxDataNext    = rxData;
        rxValidNext   = rxValid;
        frameDoneNext = 1'b0;
        overrunNext   = overrun;

        if (peripheralClkEdgePos) begin
            sampledNext = serialDataIn;
        end

        if (parallelLoad) begin
            memNext   = parallelDataIn;
            countNext = '0;
        end else if (doShift) begin
            memNext   = shifted;
            countNext = frameEnd ? '0 : bitCount + cntWidth'(1);
        end

        // A frame end outranks a same-cycle ack: the new word must stay visible.
        if (frameEnd) begin
            rxDataNext    = shifted;
            rxValidNext   = 1'b1;
            frameDoneNext = 1'b1;
            if (rxValid && !rxAck) begin
                overrunNext = 1'b1;
            end
        end else if (rxAck) begin
            rxValidNext = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mem        <= '0;
            sampledBit <= 1'b0;
            bitCount   <= '0;
            rxData     <= '0;
            rxValid    <= 1'b0;
            frameDone  <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            mem        <= memNext;
            sampledBit <= sampledNext;
            bitCount   <= countNext;
            rxData     <= rxDataNext;
            rxValid    <= rxValidNext;
            frameDone  <= frameDoneNext;
            overrun    <= overrunNext;
        end
    end

    assign parallelDataOut = mem;
    assign serialDataOut   = (lsbFirst != 0) ? mem[0] : mem[width-1];

endmodule

// File: tb/tb_framed_shiftregister.sv
// Bench for framed_shiftregister: an MSB-first and an LSB-first instance share one stimulus.
// Frame vectors come from a table, and expected receive words go through a scoreboard queue.
module tb_framed_shiftregister;

    typedef struct {
        logic [7:0] load;
        logic [7:0] inBits;   // time order, bit 7 first
        logic [7:0] rx0;      // expected rxData, MSB-first instance
        logic [7:0] rx1;      // expected rxData, LSB-first instance
        logic [7:0] ser0;     // expected serialDataOut sequence, bit 7 first
        logic [7:0] ser1;
    } frameVec;

    typedef struct {
        logic [7:0] rx0;
        logic [7:0] rx1;
    } rxExp;

    logic       clk = 1'b0;
    logic       reset, edgePos, edgeNeg, load, serIn, rxAck;
    logic [7:0] dataIn;
    logic       ser0, valid0, done0, ovr0, ser1, valid1, done1, ovr1;
    logic [7:0] pout0, rx0, pout1, rx1;
    logic [3:0] cnt0, cnt1;

    int   total = 0;
    int   bad = 0;
    int   doneCount0 = 0;
    int   doneCount1 = 0;
    rxExp sb[$];
    frameVec vecs[4];

    always #5 clk = ~clk;

    framed_shiftregister #(.width(8), .lsbFirst(0), .cntWidth(4)) dut0 (
        .clk(clk), .reset(reset), .peripheralClkEdgePos(edgePos), .peripheralClkEdgeNeg(edgeNeg),
        .parallelLoad(load), .parallelDataIn(dataIn), .serialDataIn(serIn), .rxAck(rxAck),
        .serialDataOut(ser0), .parallelDataOut(pout0), .rxData(rx0), .rxValid(valid0),
        .frameDone(done0), .overrun(ovr0), .bitCount(cnt0)
    );

    framed_shiftregister #(.width(8), .lsbFirst(1), .cntWidth(4)) dut1 (
        .clk(clk), .reset(reset), .peripheralClkEdgePos(edgePos), .peripheralClkEdgeNeg(edgeNeg),
        .parallelLoad(load), .parallelDataIn(dataIn), .serialDataIn(serIn), .rxAck(rxAck),
        .serialDataOut(ser1), .parallelDataOut(pout1), .rxData(rx1), .rxValid(valid1),
        .frameDone(done1), .overrun(ovr1), .bitCount(cnt1)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Frame-end monitor: every frameDone pulse consumes one scoreboard entry.
    always @(negedge clk) begin
        if (!reset) begin
            if (done1) doneCount1++;
            if (done0) begin
                doneCount0++;
                if (sb.size() == 0) begin
                    check("unexpectedFrameDone", 32'd1, 32'd0);
                end else begin
                    rxExp e;
                    e = sb.pop_front();
                    check("rxData0", rx0, e.rx0);
                    check("rxData1", rx1, e.rx1);
                    check("rxValidAtDone", valid0, 1'b1);
                end
            end
        end
    end

    task automatic checkAllZero(input string tag);
        check({tag, "_pdo0"}, pout0, 8'h00);
        check({tag, "_pdo1"}, pout1, 8'h00);
        check({tag, "_ser0"}, ser0, 1'b0);
        check({tag, "_cnt0"}, cnt0, 4'd0);
        check({tag, "_cnt1"}, cnt1, 4'd0);
        check({tag, "_rx0"}, rx0, 8'h00);
        check({tag, "_valid0"}, valid0, 1'b0);
        check({tag, "_valid1"}, valid1, 1'b0);
        check({tag, "_done0"}, done0, 1'b0);
        check({tag, "_ovr0"}, ovr0, 1'b0);
        check({tag, "_ovr1"}, ovr1, 1'b0);
    endtask

    task automatic risingFalling(input logic bitVal);
        serIn = bitVal; edgePos = 1'b1; tick(); edgePos = 1'b0;
        edgeNeg = 1'b1; tick(); edgeNeg = 1'b0;
    endtask

    task automatic runFrame(input frameVec v, input bit doLoad, input bit ackLast);
        int   d0, d1;
        rxExp e;
        if (doLoad) begin
            load = 1'b1; dataIn = v.load; tick(); load = 1'b0;
            check("loadPdo0", pout0, v.load);
            check("loadPdo1", pout1, v.load);
            check("loadCnt", cnt0, 4'd0);
        end
        d0 = doneCount0;
        d1 = doneCount1;
        for (int i = 0; i < 8; i++) begin
            serIn = v.inBits[7-i]; edgePos = 1'b1; tick(); edgePos = 1'b0;
            if (doLoad) begin
                check($sformatf("ser0_bit%0d", i), ser0, v.ser0[7-i]);
                check($sformatf("ser1_bit%0d", i), ser1, v.ser1[7-i]);
            end
            if (i == 7) begin
                e.rx0 = v.rx0;
                e.rx1 = v.rx1;
                sb.push_back(e);
                rxAck = ackLast;
            end
            edgeNeg = 1'b1; tick(); edgeNeg = 1'b0; rxAck = 1'b0;
            if (i < 7) check($sformatf("midCnt%0d", i), cnt0, 32'(i + 1));
        end
        check("endCnt0", cnt0, 4'd0);
        check("endCnt1", cnt1, 4'd0);
        tick();
        tick();
        check("donePulses0", 32'(doneCount0), 32'(d0 + 1));
        check("donePulses1", 32'(doneCount1), 32'(d1 + 1));
        check("postValid0", valid0, 1'b1);
        check("postValid1", valid1, 1'b1);
    endtask

    task automatic ackWord();
        rxAck = 1'b1; tick(); rxAck = 1'b0;
        check("ackValid0", valid0, 1'b0);
        check("ackValid1", valid1, 1'b0);
    endtask

    initial begin
        frameVec zeros;
        int      d0;

        vecs[0] = '{load: 8'hA5, inBits: 8'hCF, rx0: 8'hCF, rx1: 8'hF3, ser0: 8'hA5, ser1: 8'hA5};
        vecs[1] = '{load: 8'hA5, inBits: 8'h80, rx0: 8'h80, rx1: 8'h01, ser0: 8'hA5, ser1: 8'hA5};
        vecs[2] = '{load: 8'h12, inBits: 8'hB1, rx0: 8'hB1, rx1: 8'h8D, ser0: 8'h12, ser1: 8'h48};
        vecs[3] = '{load: 8'hFF, inBits: 8'h00, rx0: 8'h00, rx1: 8'h00, ser0: 8'hFF, ser1: 8'hFF};
        zeros   = '{load: 8'h00, inBits: 8'h00, rx0: 8'h00, rx1: 8'h00, ser0: 8'h00, ser1: 8'h00};

        reset = 1'b1; edgePos = 1'b0; edgeNeg = 1'b0; load = 1'b0;
        serIn = 1'b0; rxAck = 1'b0; dataIn = 8'h00;
        tick(); tick();
        reset = 1'b0;
        checkAllZero("reset");

        // Table-driven frames, each acknowledged afterwards.
        for (int k = 0; k < 4; k++) begin
            runFrame(vecs[k], 1'b1, 1'b0);
            ackWord();
            check("noOverrun0", ovr0, 1'b0);
        end

        // Unacked word followed by a second frame of zeros.
        runFrame(vecs[0], 1'b1, 1'b0);
        runFrame(zeros, 1'b0, 1'b0);
        check("overrun0", ovr0, 1'b1);
        check("overrun1", ovr1, 1'b1);
        ackWord();
        check("overrunSticky", ovr0, 1'b1);

        // Load collides with a falling strobe at bitCount=3.
        load = 1'b1; dataIn = 8'h12; tick(); load = 1'b0;
        for (int i = 0; i < 3; i++) risingFalling(1'b1);
        check("cntBeforeLoad", cnt0, 4'd3);
        d0 = doneCount0;
        load = 1'b1; dataIn = 8'h5A; edgeNeg = 1'b1; edgePos = 1'b1; serIn = 1'b0;
        tick();
        load = 1'b0; edgeNeg = 1'b0; edgePos = 1'b0;
        check("collidePdo0", pout0, 8'h5A);
        check("collidePdo1", pout1, 8'h5A);
        check("collideCnt", cnt0, 4'd0);
        edgeNeg = 1'b1; tick(); edgeNeg = 1'b0;
        check("postLoadShift0", pout0, 8'hB4);
        check("postLoadShift1", pout1, 8'h2D);
        check("noDoneOnAbort", 32'(doneCount0), 32'(d0));

        // Reset after five shifts, with strobes present in the reset cycle.
        for (int i = 0; i < 4; i++) risingFalling(1'b1);
        check("cntBeforeReset", cnt0, 4'd5);
        reset = 1'b1; edgeNeg = 1'b1; edgePos = 1'b1; serIn = 1'b1;
        tick();
        reset = 1'b0; edgeNeg = 1'b0; edgePos = 1'b0;
        checkAllZero("midReset");

        // Normal frame after reset, then a frame end that coincides with rxAck.
        runFrame(vecs[0], 1'b1, 1'b0);
        runFrame(vecs[3], 1'b1, 1'b1);
        check("ackAtEndOverrun0", ovr0, 1'b0);
        check("ackAtEndOverrun1", ovr1, 1'b0);
        ackWord();

        tick();
        check("scoreboardEmpty", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
